// File: rtl/pn_seq_gen_if.sv
// Chip-generator control and output bundle between the transmit controller
// (master) and the PN sequence generator (slave).
interface pn_seq_gen_if #(
   parameter int WIDTH = 4,
   parameter int DIV_W = 16
);
   logic             en;
   logic [DIV_W-1:0] chip_div;
   logic             load;
   logic [WIDTH-1:0] seed_in;
   logic             m_out;
   logic [WIDTH-1:0] state_out;
   logic             chip_tick;
   logic             period_start;
   logic             lockup;

   modport master (
      output en, chip_div, load, seed_in,
      input  m_out, state_out, chip_tick, period_start, lockup
   );

   modport slave (
      input  en, chip_div, load, seed_in,
      output m_out, state_out, chip_tick, period_start, lockup
   );
endinterface

// File: rtl/pn_seq_gen.sv
// Fibonacci-LFSR PN chip generator with a clock-enable chip-rate divider,
// seed reload, period-start marker and all-zero lock-up recovery.
module pn_seq_gen #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] TAPS      = 4'b1001,
   parameter logic [WIDTH-1:0] INIT_SEED = 4'b0001,
   parameter int               DIV_W     = 16
) (
   input  logic        clk,
   input  logic        rst,
   pn_seq_gen_if.slave pn
);

   function automatic logic parity(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] seed_r;
   logic [DIV_W-1:0] cnt_r;
   logic             chip_tick_r;
   logic             period_start_r;
   logic             lockup_r;

   logic             fb_s;
   logic [WIDTH-1:0] next_s;
   logic             advance_s;

   // Next LFSR state and chip-boundary decision
   always_comb begin
      fb_s      = 1'b0;
      next_s    = state_r;
      advance_s = 1'b0;
      fb_s      = parity(state_r & TAPS);
      next_s    = {fb_s, state_r[WIDTH-1:1]};
      if (pn.en && (cnt_r >= pn.chip_div)) begin
         advance_s = 1'b1;
      end else begin
         advance_s = 1'b0;
      end
   end

   // Divider, LFSR state, active seed and per-chip pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r        <= INIT_SEED;
         seed_r         <= INIT_SEED;
         cnt_r          <= {DIV_W{1'b0}};
         chip_tick_r    <= 1'b0;
         period_start_r <= 1'b0;
         lockup_r       <= 1'b0;
      end else begin
         chip_tick_r    <= 1'b0;
         period_start_r <= 1'b0;
         lockup_r       <= 1'b0;
         if (pn.load) begin
            cnt_r          <= {DIV_W{1'b0}};
            chip_tick_r    <= 1'b1;
            period_start_r <= 1'b1;
            // An all-zero seed would freeze the register, so fall back
            if (pn.seed_in == {WIDTH{1'b0}}) begin
               seed_r   <= INIT_SEED;
               state_r  <= INIT_SEED;
               lockup_r <= 1'b1;
            end else begin
               seed_r  <= pn.seed_in;
               state_r <= pn.seed_in;
            end
         end else if (advance_s) begin
            cnt_r       <= {DIV_W{1'b0}};
            chip_tick_r <= 1'b1;
            if (next_s == {WIDTH{1'b0}}) begin
               state_r        <= seed_r;
               lockup_r       <= 1'b1;
               period_start_r <= 1'b1;
            end else begin
               state_r        <= next_s;
               period_start_r <= (next_s == seed_r);
            end
         end else if (pn.en) begin
            cnt_r <= cnt_r + DIV_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign pn.m_out        = state_r[0];
   assign pn.state_out    = state_r;
   assign pn.chip_tick    = chip_tick_r;
   assign pn.period_start = period_start_r;
   assign pn.lockup       = lockup_r;

endmodule

// File: tb/tb_pn_seq_gen.sv
// Scoreboard bench for pn_seq_gen: a primitive-tap instance against a cycle
// model plus fixed sequence checks, and a degenerate-tap instance for lock-up.
module tb_pn_seq_gen;

   logic clk;
   logic rst;
   logic rst2;
   int   total;
   int   bad;

   pn_seq_gen_if #(.WIDTH(4), .DIV_W(16)) bus ();
   pn_seq_gen_if #(.WIDTH(4), .DIV_W(16)) bus2 ();

   pn_seq_gen #(.WIDTH(4), .TAPS(4'b1001), .INIT_SEED(4'b0001), .DIV_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .pn  (bus)
   );

   pn_seq_gen #(.WIDTH(4), .TAPS(4'b1000), .INIT_SEED(4'b0001), .DIV_W(16)) dut2 (
      .clk (clk),
      .rst (rst2),
      .pn  (bus2)
   );

   typedef struct packed {
      logic [3:0] state;
      logic       m;
      logic       tick;
      logic       ps;
      logic       lk;
   } exp_t;

   exp_t        sb_q[$];
   logic [3:0]  m_state;
   logic [3:0]  m_seed;
   int          m_cnt;
   logic [14:0] pat_bits;
   int          ps_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 4'b0001;
      m_seed  = 4'b0001;
      m_cnt   = 0;
   endtask

   // Drive one cycle, predict its outcome, then compare after the edge
   task automatic step(input bit e, input int div, input bit ld, input int sd);
      exp_t       x;
      logic [3:0] nx;
      bus.en       = e;
      bus.chip_div = div[15:0];
      bus.load     = ld;
      bus.seed_in  = sd[3:0];
      x = '0;
      if (ld) begin
         m_cnt = 0;
         x.tick = 1'b1;
         x.ps   = 1'b1;
         if (sd[3:0] == 4'b0000) begin
            m_seed  = 4'b0001;
            m_state = 4'b0001;
            x.lk    = 1'b1;
         end else begin
            m_seed  = sd[3:0];
            m_state = sd[3:0];
         end
      end else if (e && (m_cnt >= div)) begin
         m_cnt  = 0;
         x.tick = 1'b1;
         nx = {m_state[0] ^ m_state[3], m_state[3:1]};
         if (nx == 4'b0000) begin
            m_state = m_seed;
            x.lk    = 1'b1;
            x.ps    = 1'b1;
         end else begin
            m_state = nx;
            x.ps    = (nx == m_seed);
         end
      end else if (e) begin
         m_cnt++;
      end
      x.state = m_state;
      x.m     = m_state[0];
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      check_val("sb_state", bus.state_out, x.state);
      check_val("sb_m_out", bus.m_out, x.m);
      check_val("sb_tick", bus.chip_tick, x.tick);
      check_val("sb_pstart", bus.period_start, x.ps);
      check_val("sb_lockup", bus.lockup, x.lk);
   endtask

   task automatic pulse_rst();
      rst = 1'b0;
      #2;
      check_val("arst_state", bus.state_out, 4'b0001);
      check_val("arst_m_out", bus.m_out, 1'b1);
      check_val("arst_tick", bus.chip_tick, 1'b0);
      check_val("arst_pstart", bus.period_start, 1'b0);
      check_val("arst_lockup", bus.lockup, 1'b0);
      model_reset();
      #2;
      rst = 1'b1;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      pat_bits = 15'b001101011110001;
      rst      = 1'b0;
      rst2     = 1'b0;
      bus.en = 1'b0; bus.chip_div = 16'd0; bus.load = 1'b0; bus.seed_in = 4'd0;
      bus2.en = 1'b0; bus2.chip_div = 16'd0; bus2.load = 1'b0; bus2.seed_in = 4'd0;
      model_reset();
      #12;
      check_val("rst_state", bus.state_out, 4'b0001);
      check_val("rst_m_out", bus.m_out, 1'b1);
      check_val("rst_tick", bus.chip_tick, 1'b0);
      check_val("rst_pstart", bus.period_start, 1'b0);
      check_val("rst_lockup", bus.lockup, 1'b0);
      @(posedge clk);
      #1;
      rst  = 1'b1;
      rst2 = 1'b1;

      // Full-rate sequence over two periods
      ps_cnt = 0;
      for (int i = 1; i <= 30; i++) begin
         step(1'b1, 0, 1'b0, 0);
         check_val("pat_m_out", bus.m_out, pat_bits[i % 15]);
         check_val("pat_tick", bus.chip_tick, 1'b1);
         if (bus.period_start) ps_cnt++;
         if (i % 15 == 0) check_val("pat_ps_state", bus.state_out, 4'b0001);
      end
      check_val("pat_ps_count", ps_cnt, 2);
      step(1'b1, 0, 1'b0, 0);
      pulse_rst();

      // Divide by four
      for (int i = 1; i <= 12; i++) begin
         step(1'b1, 3, 1'b0, 0);
         check_val("div3_tick", bus.chip_tick, (i % 4 == 0) ? 1'b1 : 1'b0);
         if (i == 4)  check_val("div3_s1", bus.state_out, 4'b1000);
         if (i == 8)  check_val("div3_s2", bus.state_out, 4'b1100);
         if (i == 12) check_val("div3_s3", bus.state_out, 4'b1110);
      end
      pulse_rst();

      // Enable gap in the middle of a chip
      step(1'b1, 3, 1'b0, 0);
      step(1'b1, 3, 1'b0, 0);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 3, 1'b0, 0);
         check_val("gap_tick", bus.chip_tick, 1'b0);
         check_val("gap_state", bus.state_out, 4'b0001);
      end
      step(1'b1, 3, 1'b0, 0);
      check_val("gap_ret1_tick", bus.chip_tick, 1'b0);
      step(1'b1, 3, 1'b0, 0);
      check_val("gap_ret2_tick", bus.chip_tick, 1'b1);
      check_val("gap_ret2_state", bus.state_out, 4'b1000);

      // Load 1111 on an advance cycle, then one full period
      step(1'b1, 0, 1'b1, 15);
      check_val("ld_state", bus.state_out, 4'b1111);
      check_val("ld_tick", bus.chip_tick, 1'b1);
      check_val("ld_pstart", bus.period_start, 1'b1);
      ps_cnt = 0;
      for (int i = 1; i <= 15; i++) begin
         step(1'b1, 0, 1'b0, 0);
         if (i < 15 && bus.period_start) ps_cnt++;
      end
      check_val("ld_early_ps", ps_cnt, 0);
      check_val("ld_period_ps", bus.period_start, 1'b1);
      check_val("ld_period_state", bus.state_out, 4'b1111);

      // Zero seed falls back to INIT_SEED
      step(1'b1, 0, 1'b1, 0);
      check_val("ld0_state", bus.state_out, 4'b0001);
      check_val("ld0_lockup", bus.lockup, 1'b1);
      check_val("ld0_pstart", bus.period_start, 1'b1);
      step(1'b1, 0, 1'b0, 0);
      check_val("ld0_lockup_off", bus.lockup, 1'b0);

      // Load while disabled, then hold
      step(1'b0, 0, 1'b1, 5);
      check_val("ldoff_state", bus.state_out, 4'b0101);
      check_val("ldoff_tick", bus.chip_tick, 1'b1);
      step(1'b0, 0, 1'b0, 0);
      check_val("hold_tick", bus.chip_tick, 1'b0);
      check_val("hold_state", bus.state_out, 4'b0101);

      // Lowering chip_div mid-chip forces the advance
      step(1'b1, 5, 1'b0, 0);
      step(1'b1, 5, 1'b0, 0);
      step(1'b1, 5, 1'b0, 0);
      step(1'b1, 1, 1'b0, 0);
      check_val("lower_div_tick", bus.chip_tick, 1'b1);

      // Degenerate taps: first advance hits zero and recovers
      bus2.en = 1'b1;
      bus2.chip_div = 16'd0;
      @(posedge clk);
      #1;
      check_val("dg_state", bus2.state_out, 4'b0001);
      check_val("dg_lockup", bus2.lockup, 1'b1);
      check_val("dg_pstart", bus2.period_start, 1'b1);
      check_val("dg_tick", bus2.chip_tick, 1'b1);
      bus2.chip_div = 16'd7;
      bus2.load     = 1'b1;
      bus2.seed_in  = 4'b1010;
      @(posedge clk);
      #1;
      bus2.load = 1'b0;
      check_val("dg_ld_state", bus2.state_out, 4'b1010);
      check_val("dg_ld_tick", bus2.chip_tick, 1'b1);
      #1;
      rst2 = 1'b0;
      #1;
      check_val("dg_arst_state", bus2.state_out, 4'b0001);
      check_val("dg_arst_m_out", bus2.m_out, 1'b1);
      check_val("dg_arst_tick", bus2.chip_tick, 1'b0);
      check_val("dg_arst_pstart", bus2.period_start, 1'b0);
      check_val("dg_arst_lockup", bus2.lockup, 1'b0);
      rst2 = 1'b1;
      check_val("sb_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
